// File: rtl/spike_network.sv
// Round-robin spike arbiter: once every neuron requests, scan one neuron per cycle from
// rr_ptr, broadcast the first firing neuron's {polarity, id}, then pulse networkDone.
module spike_network #(
   parameter int TEN_DATA_WIDTH  = 2,
   parameter int NUM_NEURON      = 512,
   parameter int NEURON_ID_WIDTH = 9
) (
   input  logic                                      clk,
   input  logic                                      reset_l,
   input  logic [NUM_NEURON-1:0]                     en_network,
   input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0]      spike_vec,
   output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in,
   output logic                                      networkDone,
   output logic                                      busy,
   output logic                                      spike_err,
   output logic                                      abort_err
);

   localparam int SW = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
   localparam logic [NEURON_ID_WIDTH-1:0] LAST_ID  = NEURON_ID_WIDTH'(NUM_NEURON - 1);
   localparam logic [NEURON_ID_WIDTH:0]   LAST_CNT = (NEURON_ID_WIDTH + 1)'(NUM_NEURON - 1);
   localparam logic [TEN_DATA_WIDTH-1:0]  POL_POS  = TEN_DATA_WIDTH'(1);
   localparam logic [TEN_DATA_WIDTH-1:0]  POL_NEG  = TEN_DATA_WIDTH'(2);
   localparam logic [TEN_DATA_WIDTH-1:0]  POL_BAD  = TEN_DATA_WIDTH'(3);

   typedef enum logic [1:0] {IDLE, SCAN, DONE, RELEASE} state_t;

   state_t                             state_q, state_d;
   logic [NEURON_ID_WIDTH-1:0]         rr_ptr_q, rr_ptr_d;
   logic [NEURON_ID_WIDTH-1:0]         scan_ptr_q, scan_ptr_d, scan_nxt;
   logic [NEURON_ID_WIDTH:0]           scan_cnt_q, scan_cnt_d;
   logic [SW-1:0]                      spike_in_q, spike_in_d;
   logic                               spike_err_q, spike_err_d;
   logic                               abort_err_q, abort_err_d;
   logic [NUM_NEURON-1:0][TEN_DATA_WIDTH-1:0] spk;
   logic [TEN_DATA_WIDTH-1:0]          pol;
   logic                               all_req;

   assign spk      = spike_vec;
   assign pol      = spk[scan_ptr_q];
   assign all_req  = &en_network;
   // Wrap at NUM_NEURON, which need not be a power of two.
   assign scan_nxt = (scan_ptr_q == LAST_ID) ? '0 : scan_ptr_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      scan_ptr_d  = scan_ptr_q;
      scan_cnt_d  = scan_cnt_q;
      spike_in_d  = spike_in_q;
      spike_err_d = spike_err_q;
      abort_err_d = abort_err_q;
      case (state_q)
         IDLE: begin
            if (all_req) begin
               state_d    = SCAN;
               scan_ptr_d = rr_ptr_q;
               scan_cnt_d = '0;
            end
         end
         SCAN: begin
            // A dropped request outranks a hit found in the same cycle.
            if (!all_req) begin
               abort_err_d = 1'b1;
               state_d     = IDLE;
            end else if (pol == POL_POS || pol == POL_NEG) begin
               spike_in_d = {pol, scan_ptr_q};
               rr_ptr_d   = scan_nxt;
               state_d    = DONE;
            end else begin
               if (pol == POL_BAD) spike_err_d = 1'b1;
               scan_ptr_d = scan_nxt;
               scan_cnt_d = scan_cnt_q + 1'b1;
               if (scan_cnt_q == LAST_CNT) begin
                  spike_in_d = '0;
                  state_d    = DONE;
               end
            end
         end
         DONE:    state_d = RELEASE;
         RELEASE: if (!(|en_network)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         scan_ptr_q  <= '0;
         scan_cnt_q  <= '0;
         spike_in_q  <= '0;
         spike_err_q <= 1'b0;
         abort_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         scan_ptr_q  <= scan_ptr_d;
         scan_cnt_q  <= scan_cnt_d;
         spike_in_q  <= spike_in_d;
         spike_err_q <= spike_err_d;
         abort_err_q <= abort_err_d;
      end
   end

   // Flags are pure decodes of the state register, so no input reaches an output combinationally.
   assign spike_in    = spike_in_q;
   assign networkDone = (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign spike_err   = spike_err_q;
   assign abort_err   = abort_err_q;

endmodule

// File: tb/tb_spike_network.sv
// Bench for spike_network: directed table of arbitration rounds, randomized rounds against
// a search-based model, and hand sequences for partial request, abort and async reset.
module tb_spike_network;

   localparam int NN = 512;

   logic              clk = 1'b0;
   logic              reset_l = 1'b0;
   logic [NN-1:0]     en_network = '0;
   logic [2*NN-1:0]   spike_vec = '0;
   logic [10:0]       spike_in;
   logic              networkDone, busy, spike_err, abort_err;

   int n_vec = 0;
   int n_bad = 0;

   spike_network #(.TEN_DATA_WIDTH(2), .NUM_NEURON(NN), .NEURON_ID_WIDTH(9)) dut (
      .clk(clk), .reset_l(reset_l), .en_network(en_network), .spike_vec(spike_vec),
      .spike_in(spike_in), .networkDone(networkDone), .busy(busy),
      .spike_err(spike_err), .abort_err(abort_err));

   always #5 clk = ~clk;

   typedef struct {
      bit rst;
      int ida, pola, idb, polb;
      int epol, eid, elat;
      bit eerr;
   } vec_t;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_l    = 1'b0;
      en_network = '0;
      spike_vec  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_l = 1'b1;
   endtask

   // Reference: walk the ring from rr looking for the first legal spike.
   task automatic model(input logic [2*NN-1:0] sv, input int rr, output int epol,
                        output int eid, output int elat, output int nrr, output bit saw3);
      int p;
      epol = 0; eid = 0; elat = NN + 1; nrr = rr; saw3 = 1'b0;
      for (int k = 0; k < NN; k++) begin
         int idx;
         idx = (rr + k) % NN;
         p = int'(sv[2*idx +: 2]);
         if (p == 1 || p == 2) begin
            epol = p; eid = idx; elat = k + 2; nrr = (idx + 1) % NN;
            break;
         end
         if (p == 3) saw3 = 1'b1;
      end
   endtask

   task automatic run_round(input logic [2*NN-1:0] sv, input int epol, input int eid,
                            input int elat, input bit eserr, input bit eabort, input string tag);
      int cnt;
      bit hit;
      logic [10:0] held;
      @(negedge clk);
      spike_vec  = sv;
      en_network = '1;
      cnt = 0; hit = 1'b0;
      while (!hit && cnt < 600) begin
         @(posedge clk); #1;
         cnt++;
         hit = networkDone;
      end
      chk({tag, " latency"}, cnt, elat);
      chk({tag, " spike_in"}, spike_in, epol * 512 + eid);
      chk({tag, " spike_err"}, spike_err, eserr);
      chk({tag, " abort_err"}, abort_err, eabort);
      held = spike_in;
      en_network = '0;
      @(posedge clk); #1;
      chk({tag, " done_pulse_width"}, networkDone, 0);
      chk({tag, " hold_after_done"}, spike_in, held);
      @(posedge clk); #1;
      chk({tag, " back_to_idle"}, busy, 0);
   endtask

   function automatic logic [2*NN-1:0] mk(input int ida, input int pola, input int idb, input int polb);
      logic [2*NN-1:0] v;
      v = '0;
      if (pola != 0) v[2*ida +: 2] = 2'(pola);
      if (polb != 0) v[2*idb +: 2] = 2'(polb);
      return v;
   endfunction

   initial begin
      vec_t tbl[11];
      int m_rr, epol, eid, elat, nrr, cnt;
      bit m_err, saw3, seen;
      logic [2*NN-1:0] sv;

      tbl[0]  = '{1, 37, 1, 0, 0,     1, 37, 39, 0};
      tbl[1]  = '{1, 5, 2, 300, 2,    2, 5, 7, 0};
      tbl[2]  = '{0, 5, 2, 300, 2,    2, 300, 296, 0};
      tbl[3]  = '{0, 5, 2, 300, 2,    2, 5, 218, 0};
      tbl[4]  = '{1, 0, 0, 0, 0,      0, 0, 513, 0};
      tbl[5]  = '{0, 10, 3, 11, 1,    1, 11, 13, 1};
      tbl[6]  = '{0, 0, 0, 0, 0,      0, 0, 513, 1};
      tbl[7]  = '{0, 12, 1, 0, 0,     1, 12, 2, 1};
      tbl[8]  = '{0, 11, 1, 0, 0,     1, 11, 512, 1};
      tbl[9]  = '{1, 511, 2, 0, 0,    2, 511, 513, 0};
      tbl[10] = '{0, 0, 1, 0, 0,      1, 0, 2, 0};

      do_reset();
      #1;
      chk("reset spike_in", spike_in, 0);
      chk("reset networkDone", networkDone, 0);
      chk("reset busy", busy, 0);
      chk("reset spike_err", spike_err, 0);
      chk("reset abort_err", abort_err, 0);

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         run_round(mk(tbl[i].ida, tbl[i].pola, tbl[i].idb, tbl[i].polb),
                   tbl[i].epol, tbl[i].eid, tbl[i].elat, tbl[i].eerr, 1'b0, $sformatf("tbl%0d", i));
      end

      do_reset();
      m_rr = 0; m_err = 1'b0;
      for (int r = 0; r < 25; r++) begin
         sv = '0;
         for (int j = 0; j < int'($urandom_range(0, 2)); j++)
            sv[2*int'($urandom_range(0, NN-1)) +: 2] = 2'b11;
         for (int j = 0; j < int'($urandom_range(0, 3)); j++)
            sv[2*int'($urandom_range(0, NN-1)) +: 2] = 2'($urandom_range(1, 2));
         model(sv, m_rr, epol, eid, elat, nrr, saw3);
         m_err = m_err | saw3;
         run_round(sv, epol, eid, elat, m_err, 1'b0, $sformatf("rnd%0d", r));
         m_rr = nrr;
      end

      // Partial request never starts a scan.
      do_reset();
      @(negedge clk);
      spike_vec = mk(0, 1, 0, 0);
      en_network = '1;
      en_network[200] = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (busy || networkDone) seen = 1'b1;
      end
      chk("partial stays idle", seen, 0);

      // Hit and drop in the same SCAN cycle: drop wins.
      @(negedge clk);
      en_network = '1;
      @(posedge clk); #1;
      chk("abort_hit scan entered", busy, 1);
      @(negedge clk);
      en_network[3] = 1'b0;
      @(posedge clk); #1;
      chk("abort_hit abort_err", abort_err, 1);
      chk("abort_hit busy", busy, 0);
      chk("abort_hit spike_in", spike_in, 0);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (networkDone) seen = 1'b1;
      end
      chk("abort_hit no done", seen, 0);
      en_network = '0;
      @(posedge clk);
      run_round(mk(0, 1, 0, 0), 1, 0, 2, 1'b0, 1'b1, "after_abort");

      // Drop bit 0 deep in a no-spike scan.
      @(negedge clk);
      spike_vec = '0;
      en_network = '1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      en_network[0] = 1'b0;
      seen = 1'b0;
      cnt = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (networkDone) seen = 1'b1;
         if (busy) cnt++;
      end
      chk("midscan abort no done", seen, 0);
      chk("midscan abort idle", cnt, 0);
      chk("midscan spike_in held", spike_in, 512);
      en_network = '0;
      @(posedge clk);

      // Async reset mid-scan, then scanning restarts at neuron 0.
      run_round(mk(1, 3, 2, 2), 2, 2, 3, 1'b1, 1'b1, "pre_reset");
      @(negedge clk);
      spike_vec = '0;
      en_network = '1;
      repeat (20) @(posedge clk);
      #3;
      reset_l = 1'b0;
      #1;
      chk("async rst spike_in", spike_in, 0);
      chk("async rst busy", busy, 0);
      chk("async rst spike_err", spike_err, 0);
      chk("async rst abort_err", abort_err, 0);
      chk("async rst networkDone", networkDone, 0);
      en_network = '0;
      @(negedge clk);
      reset_l = 1'b1;
      run_round(mk(0, 1, 5, 1), 1, 0, 2, 1'b0, 1'b0, "post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
